// File: rtl/seven_segment_pkg.sv
// Shared types and glyph constants for the seven-segment display path.
// Segment patterns are active-low, bit6..0 = a..g.
package seven_segment_pkg;

  typedef logic [6:0] seg_t;

  localparam logic ANODE_OFF = 1'b1;
  localparam logic SEG_OFF   = 1'b1;

  localparam seg_t SEG_BLANK = {7{SEG_OFF}};
  localparam seg_t SEG_0 = 7'h01;
  localparam seg_t SEG_1 = 7'h4F;
  localparam seg_t SEG_2 = 7'h12;
  localparam seg_t SEG_3 = 7'h06;
  localparam seg_t SEG_4 = 7'h4C;
  localparam seg_t SEG_5 = 7'h24;
  localparam seg_t SEG_6 = 7'h20;
  localparam seg_t SEG_7 = 7'h0F;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h04;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h60;
  localparam seg_t SEG_C = 7'h31;
  localparam seg_t SEG_D = 7'h42;
  localparam seg_t SEG_E = 7'h30;
  localparam seg_t SEG_F = 7'h38;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational nibble to active-low segment glyph (0-9, A b C d E F).
// Ports: i_nibble (4-bit value), o_seg (segments a..g, active-low).
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit common-anode display driver with frame-synchronous
// updates, leading-zero blanking, blink and PWM brightness.
// Ports: clock, reset_n (async low); digits_in/dp_in/blink_mask/brightness
// captured on load; blank_lz live; anode_signals/display_out/dp_out
// active-low pins; frame_tick one-cycle pulse at frame start.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_LOG2    = 16,
  parameter int BRIGHT_BITS  = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode_signals,
  output logic [6:0]              display_out,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [SLOT_LOG2-1:0]   r_presc;
  logic [SW-1:0]          r_slot;
  logic [BW-1:0]          r_blink_cnt;
  logic                   r_blink_phase;
  logic                   r_armed;

  logic [DW-1:0]          r_sh_digits, r_ac_digits;
  logic [NUM_DIGITS-1:0]  r_sh_dp, r_ac_dp;
  logic [NUM_DIGITS-1:0]  r_sh_blink, r_ac_blink;
  logic [BRIGHT_BITS-1:0] r_sh_bright, r_ac_bright;

  logic                   w_frame_start;
  logic [DW-1:0]          w_digits;
  logic [NUM_DIGITS-1:0]  w_dp, w_blink, w_blank;
  logic [BRIGHT_BITS-1:0] w_bright;
  logic [3:0]             w_nib;
  logic                   w_cur_dp, w_cur_blink, w_cur_blank;
  logic                   w_zero_run;
  logic                   w_pwm_lit, w_on;
  seg_t                   w_glyph;
  logic [NUM_DIGITS-1:0]  w_anode;

  assign w_frame_start = (r_presc == '0) && (r_slot == '0);

  // The frame-start cycle already renders the new frame, so it sees
  // the values about to be latched into the active regs.
  always_comb begin
    w_digits = r_ac_digits;
    w_dp     = r_ac_dp;
    w_blink  = r_ac_blink;
    w_bright = r_ac_bright;
    if (w_frame_start) begin
      w_digits = load ? digits_in  : r_sh_digits;
      w_dp     = load ? dp_in      : r_sh_dp;
      w_blink  = load ? blink_mask : r_sh_blink;
      w_bright = load ? brightness : r_sh_bright;
    end
  end

  // Zero run scanned from the most significant digit downward.
  always_comb begin
    w_zero_run  = 1'b1;
    w_blank     = '0;
    w_nib       = '0;
    w_cur_dp    = 1'b0;
    w_cur_blink = 1'b0;
    w_cur_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (w_digits[4*i +: 4] == 4'h0);
      w_blank[i] = blank_lz & w_zero_run & (i != 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_slot == SW'(i)) begin
        w_nib       = w_digits[4*i +: 4];
        w_cur_dp    = w_dp[i];
        w_cur_blink = w_blink[i];
        w_cur_blank = w_blank[i];
      end
    end
  end

  seven_segment_decoder u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_glyph)
  );

  assign w_pwm_lit =
    r_presc[SLOT_LOG2-1 -: BRIGHT_BITS] <= w_bright;

  // Prescaler 0 is the inter-slot dead cycle against ghosting.
  assign w_on = (r_presc != '0) && w_pwm_lit &&
                !(w_cur_blink && r_blink_phase) &&
                (!w_cur_blank || w_cur_dp);

  assign w_anode = w_on
    ? ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_slot)
    : {NUM_DIGITS{ANODE_OFF}};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc       <= '0;
      r_slot        <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      r_presc <= r_presc + 1'b1;
      r_armed <= 1'b1;
      if (&r_presc) begin
        if (r_slot == SW'(NUM_DIGITS - 1))
          r_slot <= '0;
        else
          r_slot <= r_slot + 1'b1;
      end
      // The partial frame right after reset is not counted.
      if (w_frame_start && r_armed) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_digits <= '0;
      r_sh_dp     <= '0;
      r_sh_blink  <= '0;
      r_sh_bright <= '0;
      r_ac_digits <= '0;
      r_ac_dp     <= '0;
      r_ac_blink  <= '0;
      r_ac_bright <= '0;
    end else begin
      if (load) begin
        r_sh_digits <= digits_in;
        r_sh_dp     <= dp_in;
        r_sh_blink  <= blink_mask;
        r_sh_bright <= brightness;
      end
      if (w_frame_start) begin
        r_ac_digits <= w_digits;
        r_ac_dp     <= w_dp;
        r_ac_blink  <= w_blink;
        r_ac_bright <= w_bright;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anode_signals <= {NUM_DIGITS{ANODE_OFF}};
      display_out   <= SEG_BLANK;
      dp_out        <= SEG_OFF;
      frame_tick    <= 1'b0;
    end else begin
      anode_signals <= w_anode;
      display_out   <= w_cur_blank ? SEG_BLANK : w_glyph;
      dp_out        <= ~w_cur_dp;
      frame_tick    <= w_frame_start && r_armed;
    end
  end

endmodule
